// File: rtl/ahb_bus_arbiter_if.sv
// Request/grant bundle between the AHB masters and the bus arbiter.
// "master" is the requesting side; "slave" is the arbiter side.
interface ahb_bus_arbiter_if #(
  parameter int MasNum = 4,
  parameter int PrioW  = 2
);
  localparam int MasW = (MasNum > 1) ? $clog2(MasNum) : 1;

  logic [MasNum-1:0]       hbusreq;
  logic [MasNum-1:0]       hlock;
  logic [MasNum*PrioW-1:0] hprior;
  logic [1:0]              htrans;
  logic [2:0]              hburst;
  logic                    hready;
  logic [MasNum-1:0]       hgrant;
  logic [MasW-1:0]         hmaster;
  logic [MasW-1:0]         hmaster_data;
  logic                    hmastlock;

  modport master (
    output hbusreq, hlock, hprior, htrans, hburst, hready,
    input  hgrant, hmaster, hmaster_data, hmastlock
  );

  modport slave (
    input  hbusreq, hlock, hprior, htrans, hburst, hready,
    output hgrant, hmaster, hmaster_data, hmastlock
  );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// AHB address-phase arbiter: priority with round-robin tie-break, burst and lock
// aware handover, parking on a default master when nobody requests.
module ahb_bus_arbiter #(
  parameter int MasNum     = 4,
  parameter int PrioW      = 2,
  parameter int DefaultMas = 0
) (
  input  logic             hclk,
  input  logic             hreset,
  ahb_bus_arbiter_if.slave bus
);
  localparam int MasW = (MasNum > 1) ? $clog2(MasNum) : 1;

  localparam logic [1:0] ST_PARK    = 2'd0;
  localparam logic [1:0] ST_GRANTED = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_BUSY   = 2'd1;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;

  localparam logic [2:0] BU_INCR = 3'd1;

  localparam logic [MasW-1:0]   DEF_IDX   = MasW'(DefaultMas);
  localparam logic [MasNum-1:0] DEF_GRANT = {{(MasNum-1){1'b0}}, 1'b1} << DefaultMas;

  logic [1:0]        state_r;
  logic [3:0]        cnt_r;
  logic [MasW-1:0]   rr_r;
  logic [MasW-1:0]   hmaster_r;
  logic [MasW-1:0]   hmaster_data_r;
  logic [MasNum-1:0] hgrant_r;
  logic              hmastlock_r;

  logic [3:0]        cnt_nxt_s;
  logic              hp_s;
  logic              any_req_s;
  logic              owner_req_s;
  logic              owner_lock_s;
  logic              found_s;
  logic [PrioW-1:0]  best_s;
  logic [MasW-1:0]   win_s;
  logic              rearb_s;
  logic [1:0]        state_nxt_s;
  logic [MasW-1:0]   master_nxt_s;
  logic [MasW-1:0]   rr_nxt_s;
  logic [MasNum-1:0] grant_nxt_s;

  // Remaining beats minus one for a burst starting with NONSEQ.
  function automatic logic [3:0] burst_beats(input logic [2:0] burst);
    logic [3:0] beats;
    case (burst)
      3'd2, 3'd3: beats = 4'd3;
      3'd4, 3'd5: beats = 4'd7;
      3'd6, 3'd7: beats = 4'd15;
      default:    beats = 4'd0;
    endcase
    return beats;
  endfunction

  assign any_req_s    = |bus.hbusreq;
  assign owner_req_s  = bus.hbusreq[hmaster_r];
  assign owner_lock_s = bus.hlock[hmaster_r];

  // Beat counter value after the current address phase is accepted.
  always_comb begin
    cnt_nxt_s = cnt_r;
    case (bus.htrans)
      TR_IDLE:   cnt_nxt_s = 4'd0;
      TR_BUSY:   cnt_nxt_s = cnt_r;
      TR_NONSEQ: cnt_nxt_s = burst_beats(bus.hburst);
      TR_SEQ:    cnt_nxt_s = (cnt_r == 4'd0) ? 4'd0 : cnt_r - 4'd1;
      default:   cnt_nxt_s = cnt_r;
    endcase
  end

  // Handover point: INCR ends when the owner withdraws its request.
  always_comb begin
    hp_s = 1'b0;
    if (bus.hready) begin
      case (bus.htrans)
        TR_IDLE:           hp_s = 1'b1;
        TR_NONSEQ, TR_SEQ: hp_s = (bus.hburst == BU_INCR) ? !owner_req_s
                                                          : (cnt_nxt_s == 4'd0);
        default:           hp_s = 1'b0;
      endcase
    end else begin
      hp_s = 1'b0;
    end
  end

  // Highest priority wins; strict compare keeps the first tied master after rr_r.
  always_comb begin
    found_s = 1'b0;
    best_s  = '0;
    win_s   = rr_r;
    for (int k = 0; k < MasNum; k++) begin
      if (bus.hbusreq[(int'(rr_r) + k + 1) % MasNum] &&
          (!found_s || (bus.hprior[((int'(rr_r) + k + 1) % MasNum)*PrioW +: PrioW] > best_s))) begin
        found_s = 1'b1;
        best_s  = bus.hprior[((int'(rr_r) + k + 1) % MasNum)*PrioW +: PrioW];
        win_s   = MasW'((int'(rr_r) + k + 1) % MasNum);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Ownership decision taken at each handover point.
  always_comb begin
    state_nxt_s  = state_r;
    master_nxt_s = hmaster_r;
    rr_nxt_s     = rr_r;
    rearb_s      = 1'b0;
    if (hp_s) begin
      case (state_r)
        ST_PARK: begin
          if (any_req_s && !((win_s == DEF_IDX) && !bus.hlock[win_s])) begin
            rearb_s = 1'b1;
          end else if (any_req_s) begin
            master_nxt_s = DEF_IDX;
            rr_nxt_s     = win_s;
          end else begin
            master_nxt_s = DEF_IDX;
          end
        end
        ST_GRANTED: rearb_s = 1'b1;
        ST_LOCKED:  rearb_s = !owner_lock_s;
        default: begin
          state_nxt_s  = ST_PARK;
          master_nxt_s = DEF_IDX;
        end
      endcase
      if (rearb_s && any_req_s) begin
        master_nxt_s = win_s;
        rr_nxt_s     = win_s;
        state_nxt_s  = bus.hlock[win_s] ? ST_LOCKED : ST_GRANTED;
      end else if (rearb_s) begin
        master_nxt_s = DEF_IDX;
        state_nxt_s  = ST_PARK;
      end else begin
        rr_nxt_s = rr_nxt_s;
      end
    end else begin
      state_nxt_s = state_r;
    end
    grant_nxt_s = {{(MasNum-1){1'b0}}, 1'b1} << master_nxt_s;
  end

  // State and outputs advance only on accepted (hready=1) edges.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_r        <= ST_PARK;
      cnt_r          <= 4'd0;
      rr_r           <= DEF_IDX;
      hmaster_r      <= DEF_IDX;
      hmaster_data_r <= DEF_IDX;
      hgrant_r       <= DEF_GRANT;
      hmastlock_r    <= 1'b0;
    end else if (bus.hready) begin
      state_r        <= state_nxt_s;
      cnt_r          <= cnt_nxt_s;
      rr_r           <= rr_nxt_s;
      hmaster_r      <= master_nxt_s;
      hmaster_data_r <= hmaster_r;
      hgrant_r       <= grant_nxt_s;
      hmastlock_r    <= (state_nxt_s == ST_LOCKED);
    end
  end

  assign bus.hgrant       = hgrant_r;
  assign bus.hmaster      = hmaster_r;
  assign bus.hmaster_data = hmaster_data_r;
  assign bus.hmastlock    = hmastlock_r;
endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench: expected owner/data-owner/lock values are queued with each
// stimulus step and compared one cycle later after the clock edge.
module tb_ahb_bus_arbiter;
  logic hclk;
  logic hreset;
  int   checks;
  int   errors;

  typedef struct packed {
    logic [1:0] m;
    logic [1:0] d;
    logic       l;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  ahb_bus_arbiter_if #(.MasNum(4), .PrioW(2)) bif ();

  ahb_bus_arbiter #(.MasNum(4), .PrioW(2), .DefaultMas(0)) dut (
    .hclk  (hclk),
    .hreset(hreset),
    .bus   (bif)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic drive(input logic [3:0] req, input logic [3:0] lck, input logic [7:0] pri,
                       input logic [1:0] tr, input logic [2:0] bu, input logic rdy, input logic rst);
    bif.hbusreq = req;
    bif.hlock   = lck;
    bif.hprior  = pri;
    bif.htrans  = tr;
    bif.hburst  = bu;
    bif.hready  = rdy;
    hreset      = rst;
  endtask

  task automatic tick(input string tag, input int m, input int d, input bit l);
    exp_t       e;
    string      t;
    logic [3:0] eg;
    e.m = m[1:0];
    e.d = d[1:0];
    e.l = l;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge hclk);
    #1;
    e  = exp_q.pop_front();
    t  = tag_q.pop_front();
    eg = 4'b0001 << e.m;
    checks++;
    assert (bif.hgrant === eg) else begin
      errors++;
      $error("FAIL %s hgrant: observed %b expected %b", t, bif.hgrant, eg);
    end
    checks++;
    assert (bif.hmaster === e.m) else begin
      errors++;
      $error("FAIL %s hmaster: observed %0d expected %0d", t, bif.hmaster, e.m);
    end
    checks++;
    assert (bif.hmaster_data === e.d) else begin
      errors++;
      $error("FAIL %s hmaster_data: observed %0d expected %0d", t, bif.hmaster_data, e.d);
    end
    checks++;
    assert (bif.hmastlock === e.l) else begin
      errors++;
      $error("FAIL %s hmastlock: observed %b expected %b", t, bif.hmastlock, e.l);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // reset
    drive(4'b0000, 4'b0000, 8'h55, 2'd0, 3'd0, 1'b1, 1'b1);
    tick("reset0", 0, 0, 0);
    tick("reset1", 0, 0, 0);

    // park for 10 cycles
    drive(4'b0000, 4'b0000, 8'h55, 2'd0, 3'd0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) tick("park", 0, 0, 0);

    // priority: master 2 has hprior=3
    drive(4'b0110, 4'b0000, 8'h75, 2'd0, 3'd0, 1'b1, 1'b0);
    tick("prio_win2", 2, 0, 0);
    drive(4'b0110, 4'b0000, 8'h75, 2'd2, 3'd0, 1'b1, 1'b0);
    tick("prio_keep2", 2, 2, 0);
    drive(4'b0010, 4'b0000, 8'h75, 2'd0, 3'd0, 1'b1, 1'b0);
    tick("prio_then1", 1, 2, 0);
    drive(4'b0000, 4'b0000, 8'h75, 2'd0, 3'd0, 1'b1, 1'b0);
    tick("prio_park", 0, 1, 0);
    tick("prio_idle", 0, 0, 0);

    // round-robin from a fresh pointer
    drive(4'b0000, 4'b0000, 8'h55, 2'd0, 3'd0, 1'b1, 1'b1);
    tick("rr_reset", 0, 0, 0);
    drive(4'b1111, 4'b0000, 8'h55, 2'd0, 3'd0, 1'b1, 1'b0);
    tick("rr_g1", 1, 0, 0);
    drive(4'b1111, 4'b0000, 8'h55, 2'd2, 3'd0, 1'b1, 1'b0);
    tick("rr_g2", 2, 1, 0);
    tick("rr_g3", 3, 2, 0);
    tick("rr_g0", 0, 3, 0);
    tick("rr_g1b", 1, 0, 0);
    tick("rr_g2b", 2, 1, 0);
    drive(4'b0000, 4'b0000, 8'h55, 2'd0, 3'd0, 1'b1, 1'b0);
    tick("rr_park", 0, 2, 0);
    tick("rr_idle", 0, 0, 0);

    // burst hold: master 3 INCR8, master 1 at higher priority
    drive(4'b1000, 4'b0000, 8'h4C, 2'd0, 3'd0, 1'b1, 1'b0);
    tick("burst_g3", 3, 0, 0);
    drive(4'b1010, 4'b0000, 8'h4C, 2'd2, 3'd5, 1'b1, 1'b0);
    tick("burst_b1", 3, 3, 0);
    drive(4'b1010, 4'b0000, 8'h4C, 2'd3, 3'd5, 1'b1, 1'b0);
    tick("burst_b2", 3, 3, 0);
    tick("burst_b3", 3, 3, 0);
    drive(4'b1010, 4'b0000, 8'h4C, 2'd3, 3'd5, 1'b0, 1'b0);
    tick("burst_wait1", 3, 3, 0);
    tick("burst_wait2", 3, 3, 0);
    drive(4'b1010, 4'b0000, 8'h4C, 2'd3, 3'd5, 1'b1, 1'b0);
    tick("burst_b4", 3, 3, 0);
    tick("burst_b5", 3, 3, 0);
    tick("burst_b6", 3, 3, 0);
    tick("burst_b7", 3, 3, 0);
    tick("burst_b8", 1, 3, 0);
    drive(4'b0010, 4'b0000, 8'h4C, 2'd2, 3'd0, 1'b1, 1'b0);
    tick("burst_m1", 1, 1, 0);
    drive(4'b0000, 4'b0000, 8'h4C, 2'd0, 3'd0, 1'b1, 1'b0);
    tick("burst_park", 0, 1, 0);
    tick("burst_idle", 0, 0, 0);

    // lock: master 1 locked, master 2 at higher priority
    drive(4'b0010, 4'b0010, 8'h34, 2'd0, 3'd0, 1'b1, 1'b0);
    tick("lock_g1", 1, 0, 1);
    drive(4'b0110, 4'b0010, 8'h34, 2'd2, 3'd0, 1'b1, 1'b0);
    tick("lock_t1", 1, 1, 1);
    tick("lock_t2", 1, 1, 1);
    tick("lock_t3", 1, 1, 1);
    drive(4'b0110, 4'b0010, 8'h34, 2'd0, 3'd0, 1'b1, 1'b0);
    tick("lock_idle_held", 1, 1, 1);
    drive(4'b0100, 4'b0000, 8'h34, 2'd0, 3'd0, 1'b1, 1'b0);
    tick("lock_release", 2, 1, 0);
    drive(4'b0000, 4'b0000, 8'h34, 2'd2, 3'd0, 1'b1, 1'b0);
    tick("lock_park", 0, 2, 0);
    drive(4'b0000, 4'b0000, 8'h34, 2'd0, 3'd0, 1'b1, 1'b0);
    tick("lock_idle", 0, 0, 0);

    // reset in the middle of a WRAP4 burst
    drive(4'b0100, 4'b0000, 8'h55, 2'd0, 3'd0, 1'b1, 1'b0);
    tick("rst_g2", 2, 0, 0);
    drive(4'b0100, 4'b0000, 8'h55, 2'd2, 3'd2, 1'b1, 1'b0);
    tick("rst_b1", 2, 2, 0);
    checks++;
    assert (dut.cnt_r === 4'd3) else begin
      errors++;
      $error("FAIL rst_b1_cnt: observed %0d expected %0d", dut.cnt_r, 4'd3);
    end
    drive(4'b0100, 4'b0000, 8'h55, 2'd3, 3'd2, 1'b1, 1'b1);
    tick("rst_mid", 0, 0, 0);
    checks++;
    assert (dut.cnt_r === 4'd0) else begin
      errors++;
      $error("FAIL rst_mid_cnt: observed %0d expected %0d", dut.cnt_r, 4'd0);
    end
    checks++;
    assert (dut.state_r === 2'd0) else begin
      errors++;
      $error("FAIL rst_mid_state: observed %0d expected %0d", dut.state_r, 2'd0);
    end
    drive(4'b0010, 4'b0000, 8'h55, 2'd0, 3'd0, 1'b1, 1'b0);
    tick("rst_after", 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ahb_bus_arbiter.md
Name: ahb_bus_arbiter

Overview:
- Arbiter for the multi-master AHB bus matrix (4 masters, including kemee, onto shared slaves).
- Selects the address-phase owner from the hbusreq/hprior inputs. Highest priority wins; round-robin breaks ties.
- Honours fixed-length bursts and locked transfers. Parks on a default master when idle.
- Drives hgrant, hmaster and hmastlock for the bus mux, plus hmaster_data for the read/response mux.

Parameters:
- MasNum, 4, number of masters.
- PrioW, 2, width of each master's priority field; a larger value means higher priority.
- DefaultMas, 0, index of the parking master.

Ports:
- hclk  input  1  bus clock.
- hreset  input  1  synchronous, active-high reset.
- hbusreq  input  MasNum  bus request, one bit per master.
- hlock  input  MasNum  lock request, one bit per master.
- hprior  input  MasNum*PrioW  priorities; master i uses bits [i*PrioW +: PrioW].
- htrans  input  2  HTRANS of the current address-phase owner (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- hburst  input  3  HBURST of the current owner (SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7).
- hready  input  1  bus-level HREADY.
- hgrant  output  MasNum  one-hot grant.
- hmaster  output  clog2(MasNum)  address-phase owner index.
- hmaster_data  output  clog2(MasNum)  data-phase owner index.
- hmastlock  output  1  current transfer is locked.

Behaviour:
- Single clock domain: all state updates on hclk rising edge.
- Reset (hreset=1 at an edge), regardless of any burst in flight:
  - hgrant = one-hot(DefaultMas); hmaster = hmaster_data = DefaultMas; hmastlock = 0.
  - Beat counter = 0; round-robin pointer = DefaultMas; state = PARK.
- Freeze: while hready=0, no register changes except under reset.
- Beat counter (4 bits), updated only when hready=1:
  - NONSEQ loads beats-1: 0 for SINGLE/INCR, 3 for x4, 7 for x8, 15 for x16.
  - SEQ decrements, saturating at 0.
  - IDLE clears to 0.
  - BUSY holds.
- Handover point (HP) = hready=1 AND one of:
  - htrans=IDLE;
  - htrans in {NONSEQ, SEQ} with counter-after-update = 0 and hburst != INCR;
  - hburst=INCR with htrans in {NONSEQ, SEQ} and the owner's hbusreq=0.
  - BUSY is never an HP.
- States:
  - PARK: the granted master is not requesting. Any request at an HP gives GRANTED, except DefaultMas requesting without hlock, which stays in PARK.
  - GRANTED: at each HP, re-arbitrate. No requests at all gives PARK with DefaultMas granted. A winner with hlock=1 gives LOCKED.
  - LOCKED: no re-arbitration while the owner holds hlock=1. At the first HP with the owner's hlock=0, arbitrate as in GRANTED.
- Arbitration (combinational, sampled at the HP):
  - Candidates are masters with hbusreq=1; the winner has the maximum hprior.
  - Ties go to the first tied master scanning upward, with wrap, from rr_pointer+1.
  - The current owner competes normally.
  - On a new grant, rr_pointer is set to the winner.
- Grant latency: the decision at an HP edge appears on hgrant/hmaster at that same edge, as a registered output visible the cycle after the HP cycle. The new owner's first NONSEQ is sampled the following cycle.
- hmaster_data: loads hmaster at every edge with hready=1.
- hmastlock: registered; equals 1 in the cycle after a locked owner's address-phase edge with hready=1; clears once the owner drops hlock and an HP occurs.
- Outputs: hgrant is always exactly one-hot; hmaster always equals the index of the hgrant bit.
- Invalid input: an hprior change mid-burst has no effect until the next HP.

Test Plan:
- Park: reset, then all hbusreq=0 for 10 cycles -> hgrant=4'b0001, hmaster=0, hmastlock=0 throughout.
- Priority: all hprior equal except master 2 hprior=3; masters 1 and 2 request at an HP -> next cycle hgrant=4'b0100, hmaster=2; after master 2 goes IDLE, master 1 is granted.
- Round-robin: all hprior=1; masters 0-3 request continuously with SINGLE transfers -> grant order 1,2,3,0,1… (rr_pointer starts at 0), one grant change per transfer.
- Burst hold: master 3 INCR8 with hready low for 2 cycles on beat 4, master 1 requesting at higher priority -> grant stays 3 until the 8th beat is accepted; hgrant=4'b0010 the cycle after; hmaster_data lags hmaster by one hready edge.
- Lock: master 1 issues NONSEQ with hlock=1 across 3 SINGLE transfers while master 2 requests at higher priority -> hmastlock=1, grant remains master 1 until hlock drops and IDLE is seen, then master 2.
- Reset mid-burst: hreset=1 during beat 2 of master 2 WRAP4 -> next edge hgrant=4'b0001, hmaster=hmaster_data=0, counter=0, state PARK.
